// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 (x^31 + x^28 + 1) receive checker: FILL -> HUNT -> LOCKED with windowed loss-of-lock.
// Optional locked-bit counter output enabled by defining PRBS_CHK_BITCNT_EN.
module prbs31_checker #(
  parameter int LOCK_CNT    = 64,
  parameter int WIN_LEN     = 1024,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             clr,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             lock_lost,
  output logic             zero_stream
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN_LEN + 1);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);
  localparam logic [WERR_W-1:0]  WERR_LIM   = WERR_W'(LOSS_THRESH);

  typedef enum logic [1:0] {
    FILL   = 2'b00,
    HUNT   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t              cur_state, state_nx;
  logic [30:0]         hist, hist_nx;
  logic [4:0]          fill_cnt, fill_nx;
  logic [MATCH_W-1:0]  match_cnt, match_nx;
  logic [WIN_W-1:0]    win_cnt, win_nx;
  logic [WERR_W-1:0]   win_err, win_err_nx;
  logic [WERR_W-1:0]   werr_sum;
  logic                pred;
  logic                mismatch;
  logic                hit;
  logic                err_hit;
  logic                lost_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign pred     = hist[30] ^ hist[27];
  assign mismatch = bit_in ^ pred;
  // A match against an all-zero history is not evidence of PRBS, so it never advances lock.
  assign hit      = !mismatch && (|hist);
  assign werr_sum = win_err + WERR_W'(mismatch);

  always_ff @(posedge clk) begin
    if (rst_n) cur_state <= FILL;
    else       cur_state <= state_nx;
  end

  always_comb begin
    state_nx   = cur_state;
    hist_nx    = hist;
    fill_nx    = fill_cnt;
    match_nx   = match_cnt;
    win_nx     = win_cnt;
    win_err_nx = win_err;
    err_hit    = 1'b0;
    lost_set   = 1'b0;
    if (bit_vld) begin
      case (cur_state)
        FILL: begin
          hist_nx = {hist[29:0], bit_in};
          if (fill_cnt == 5'd30) begin
            state_nx = HUNT;
            fill_nx  = 5'd0;
            match_nx = '0;
          end else begin
            fill_nx = fill_cnt + 5'd1;
          end
        end
        HUNT: begin
          hist_nx  = {hist[29:0], bit_in};
          match_nx = hit ? match_cnt + MATCH_W'(1) : '0;
          if (hit && (match_cnt == MATCH_LAST)) begin
            state_nx   = LOCKED;
            match_nx   = '0;
            win_nx     = '0;
            win_err_nx = '0;
          end
        end
        LOCKED: begin
          // Feed back the prediction so one line error is not echoed by the taps.
          hist_nx = {hist[29:0], pred};
          err_hit = mismatch;
          if (werr_sum >= WERR_LIM) begin
            state_nx = FILL;
            lost_set = 1'b1;
            fill_nx  = 5'd0;
          end else if (win_cnt == WIN_LAST) begin
            win_nx     = '0;
            win_err_nx = '0;
          end else begin
            win_nx     = win_cnt + WIN_W'(1);
            win_err_nx = werr_sum;
          end
        end
        default: state_nx = FILL;
      endcase
    end
  end

  // Registered datapath and status outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      hist        <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_cnt     <= '0;
      lock_lost   <= 1'b0;
      zero_stream <= 1'b0;
    end else begin
      hist      <= hist_nx;
      fill_cnt  <= fill_nx;
      match_cnt <= match_nx;
      win_cnt   <= win_nx;
      win_err   <= win_err_nx;
      locked    <= (state_nx == LOCKED);
      err_pulse <= err_hit;
      if (bit_vld) zero_stream <= (hist_nx == 31'd0);
      if (clr) begin
        err_cnt   <= '0;
        lock_lost <= 1'b0;
      end else begin
        if (err_hit)  err_cnt   <= sat_inc(err_cnt);
        if (lost_set) lock_lost <= 1'b1;
      end
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  always_ff @(posedge clk) begin
    if (rst_n || clr)                          bit_cnt <= '0;
    else if (bit_vld && (cur_state == LOCKED)) bit_cnt <= sat_inc32(bit_cnt);
  end
`endif

  assign state = cur_state;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: lock, single error, loss/relock, window edges, zero stream, gaps and clr.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_vld = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic [1:0]  state;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic        lock_lost;
  logic        zero_stream;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_cnt;
`endif

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [30:0] g;

  prbs31_checker dut (
    .clk(clk),
    .rst_n(rst_n),
    .bit_in(bit_in),
    .bit_vld(bit_vld),
    .clr(clr),
    .locked(locked),
    .state(state),
    .err_pulse(err_pulse),
    .err_cnt(err_cnt),
    .lock_lost(lock_lost),
    .zero_stream(zero_stream)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_cnt(bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic c);
    bit_in  = b;
    bit_vld = v;
    clr     = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
    if (err_pulse) pulses++;
  endtask

  // Next generator bit from the x^31 + x^28 + 1 LFSR, optionally inverted on the wire.
  task automatic send_gen(input logic inv, input logic c);
    logic nb;
    nb = g[30] ^ g[27];
    g  = {g[29:0], nb};
    step(nb ^ inv, 1'b1, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (3) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    rst_n  = 1'b0;
    g      = 31'd1;
    pulses = 0;
  endtask

  task automatic lock_up();
    repeat (95) send_gen(1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_zero_stream", zero_stream, 0);

    // Clean lock timing
    repeat (30) send_gen(1'b0, 1'b0);
    check("fill_30", state, 0);
    send_gen(1'b0, 1'b0);
    check("hunt_31", state, 1);
    repeat (63) send_gen(1'b0, 1'b0);
    check("hunt_94", state, 1);
    check("unlocked_94", locked, 0);
    send_gen(1'b0, 1'b0);
    check("lock_95_state", state, 2);
    check("lock_95_locked", locked, 1);
    repeat (2000) send_gen(1'b0, 1'b0);
    check("clean_err_cnt", err_cnt, 0);
    check("clean_pulses", pulses, 0);
    check("clean_locked", locked, 1);
    check("clean_zero_stream", zero_stream, 0);

    // Single error
    send_gen(1'b1, 1'b0);
    check("single_pulse", err_pulse, 1);
    check("single_err_cnt", err_cnt, 1);
    check("single_locked", locked, 1);
    send_gen(1'b0, 1'b0);
    check("single_pulse_off", err_pulse, 0);
    repeat (50) send_gen(1'b0, 1'b0);
    check("single_err_cnt_hold", err_cnt, 1);
    check("single_pulses", pulses, 1);

    // Loss of lock and relock
    do_reset();
    lock_up();
    repeat (100) send_gen(1'b0, 1'b0);
    repeat (7) send_gen(1'b1, 1'b0);
    check("loss_7_locked", locked, 1);
    check("loss_7_err_cnt", err_cnt, 7);
    send_gen(1'b1, 1'b0);
    check("loss_8_state", state, 0);
    check("loss_8_locked", locked, 0);
    check("loss_8_lock_lost", lock_lost, 1);
    check("loss_8_err_cnt", err_cnt, 8);
    repeat (94) send_gen(1'b0, 1'b0);
    check("relock_94", state, 1);
    send_gen(1'b0, 1'b0);
    check("relock_95", state, 2);
    check("relock_lock_lost", lock_lost, 1);
    step(1'b0, 1'b0, 1'b1);
    check("clr_lock_lost", lock_lost, 0);
    check("clr_err_cnt", err_cnt, 0);
    check("clr_keeps_lock", locked, 1);

    // Reset mid-operation beats bit_vld and clr
    repeat (5) send_gen(1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    check("midrst_state", state, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_locked", locked, 0);

    // Seven errors, then one in the next window: stays locked
    do_reset();
    lock_up();
    for (int k = 0; k < 1040; k++)
      send_gen(((k >= 10) && (k <= 16)) || (k == 1030), 1'b0);
    check("win_next_locked", locked, 1);
    check("win_next_err_cnt", err_cnt, 8);
    check("win_next_pulses", pulses, 8);

    // Eight errors ending on the last bit of a window: loses lock
    do_reset();
    lock_up();
    for (int k = 0; k < 1024; k++) begin
      send_gen(k >= 1016, 1'b0);
      if (k == 1022) check("win_edge_7_locked", locked, 1);
    end
    check("win_edge_state", state, 0);
    check("win_edge_lock_lost", lock_lost, 1);

    // All-zero stream never locks
    do_reset();
    repeat (200) step(1'b0, 1'b1, 1'b0);
    check("zero_state", state, 1);
    check("zero_stream", zero_stream, 1);
    check("zero_locked", locked, 0);

    // Gapped stream, then clr coinciding with an error
    do_reset();
    for (int i = 0; i < 95; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 93) check("gap_94_valid", state, 1);
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (i == 93) check("gap_94_hold", state, 1);
    end
    check("gap_locked", locked, 1);
    check("gap_state", state, 2);
    check("gap_pulses", pulses, 0);
`ifdef PRBS_CHK_BITCNT_EN
    check("bitcnt_zero", bit_cnt, 0);
    repeat (10) send_gen(1'b0, 1'b0);
    check("bitcnt_ten", bit_cnt, 10);
`endif
    send_gen(1'b1, 1'b1);
    check("clr_err_pulse", err_pulse, 1);
    check("clr_err_same_cycle", err_cnt, 0);
    check("clr_lost_same_cycle", lock_lost, 0);
`ifdef PRBS_CHK_BITCNT_EN
    check("bitcnt_clr", bit_cnt, 0);
`endif
    send_gen(1'b1, 1'b0);
    check("post_clr_err_cnt", err_cnt, 1);
    check("post_clr_locked", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side companion to the PRBS31 generator (polynomial x^31 + x^28 + 1). Sits directly downstream and consumes its serial output after loopback through the pads.
- Self-synchronises to the incoming bit stream, declares lock, then counts bit errors and detects loss of lock.
- Provides error and lock status to the top-level output pins.

Parameters:
- LOCK_CNT, 64: consecutive matching bits required in HUNT before declaring lock.
- WIN_LEN, 1024: length, in valid bits, of the loss-of-lock observation window.
- LOSS_THRESH, 8: mismatches within one window that force loss of lock.
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset. Synchronous and active-high: the block resets when rst_n=1 at a rising clk edge. The name follows the codebase pin convention.
- bit_in  input  1  received serial PRBS bit.
- bit_vld  input  1  bit_in is sampled only when this is 1; otherwise all state holds.
- clr  input  1  synchronous clear of err_cnt and lock_lost (and bit_cnt when enabled).
- locked  output  1  1 while in LOCKED.
- state  output  2  00 FILL, 01 HUNT, 10 LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatched bit while LOCKED.
- err_cnt  output  CNT_W  saturating count of LOCKED mismatches.
- lock_lost  output  1  sticky; set on any LOCKED-to-FILL transition.
- zero_stream  output  1  1 while the history register is all-zero.

Behaviour:
- Reset values: all outputs 0, state=FILL, history hist[30:0]=0, all internal counters 0.
- Prediction: hist[0] holds the most recent bit. pred = hist[30] ^ hist[27]. Every valid bit shifts in at hist[0], moving hist[29:0] to hist[30:1].
- All outputs are registered and update on the edge that samples the valid bit (1-cycle latency).
- FILL:
  - Each valid bit shifts bit_in into hist; fill counter increments.
  - On the 31st valid bit, go to HUNT with match counter=0.
- HUNT:
  - Each valid bit shifts bit_in into hist.
  - If bit_in==pred and hist is nonzero before the shift: match counter +1. Otherwise: match counter=0.
  - When the match counter reaches LOCK_CNT, go to LOCKED, window counter=0, window error count=0.
- LOCKED:
  - Each valid bit shifts pred (not bit_in) into hist, so a single channel error is counted once and not multiplied by the taps.
  - On mismatch: err_pulse=1 next cycle; err_cnt +1, saturating at 2^CNT_W-1; window error count +1.
  - Window counter counts valid bits 0..WIN_LEN-1, then wraps. On the wrap, window error count resets to 0. A mismatch on the final bit of a window is evaluated against the threshold before the reset.
  - If window error count reaches LOSS_THRESH: go to FILL, lock_lost=1, fill counter=0, hist is retained.
- zero_stream = (hist == 0), registered. An all-zero input never locks.
- bit_vld=0: no state, counter or history change; err_pulse=0.
- clr:
  - Clears err_cnt and lock_lost only; state and lock are unaffected.
  - clr has priority over a same-cycle error increment: err_cnt=0 and lock_lost=0 after that edge.
  - err_pulse still fires for that bit.
- rst_n asserted mid-operation: full return to reset values on that edge, regardless of bit_vld or clr.

Optional Feature:
- Macro: PRBS_CHK_BITCNT_EN.
- When defined:
  - Adds output bit_cnt [31:0]: count of valid bits received while LOCKED, saturating at 0xFFFFFFFF.
  - Reset and clr set it to 0. clr has priority over a same-cycle increment.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles with random bit_in/bit_vld -> all outputs 0, state=00, zero_stream=0.
- Clean lock: feed the generator stream from seed 31'b1, bit_vld=1 -> state=01 after 31 bits; locked=1 and state=10 the cycle after the 95th valid bit; err_cnt stays 0 for 2000 bits.
- Single error: after lock, invert one bit -> err_pulse high exactly once; err_cnt=1; locked stays 1; no further errors.
- Loss of lock: after lock, invert 8 bits within one 1024-bit window -> after the 8th: state=00, lock_lost=1, err_cnt=8. Stream continues -> relock 95 valid bits later; lock_lost remains 1 until clr.
- Window reset and zero stream:
  - 7 errors, then 1 error early in the next window -> stays locked, err_cnt=8.
  - All-zero input for 200 bits from reset -> never leaves HUNT; zero_stream=1.
- Gaps and clr: clean stream with bit_vld toggling 1/0 -> lock after 95 valid bits (~190 cycles). Assert clr in the same cycle as an error -> err_cnt=0 next cycle and err_pulse=1. With PRBS_CHK_BITCNT_EN: bit_cnt=0 after that clr.
